// File: rtl/rtl_div_pkg.sv
// Shared definitions for the sequential divider: FSM state type, default
// operand width and the fill bit of the divide-by-zero quotient.
package rtl_div_pkg;

    // Default operand/result width of the divider datapath.
    localparam int DIV_WIDTH = 32;

    // Every bit of the divide-by-zero quotient takes this value (all ones).
    localparam logic DIV_ZERO_QBIT = 1'b1;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_subtract_stage.sv
// Combinational WIDTH+1-bit trial subtractor for the restoring divider.
// The difference is formed as a + ~b + 1 on the adder; a clear carry out
// of the top bit means the subtraction borrowed.
module div_subtract_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    logic [WIDTH+1:0] sum;

    // Add the inverted subtrahend with carry-in of one.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{(WIDTH+1){1'b0}}, 1'b1};
        diff   = sum[WIDTH:0];
        borrow = ~sum[WIDTH+1];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per cycle.
// Operands enter through in_valid/in_ready; results leave through
// out_valid/out_ready. A transfer happens on a rising edge where valid and
// ready are both high; the source holds its data stable while valid is high
// and ready is low.
// Optional signed mode: define SEQ_DIVIDER_SIGNED_EN to add the signed_op port.
module seq_divider
    import rtl_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_sr;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    count;
    logic             neg_q;
    logic             neg_r;

    logic             sop;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_quo;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic             diff_msb_unused;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign sop = signed_op;
`else
    assign sop = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;

    // The top difference bit is always zero when no borrow occurs.
    assign diff_msb_unused = diff[WIDTH];

    div_subtract_stage #(.WIDTH(WIDTH)) u_sub (
        .a      (trial_a),
        .b      (trial_b),
        .diff   (diff),
        .borrow (borrow)
    );

    // Operand magnitudes at accept, trial step and sign fixup of the final step.
    always_comb begin
        dvd_mag  = (sop && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
        dvs_mag  = (sop && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
        trial_a  = {rem_q, quo_sr[WIDTH-1]};
        trial_b  = {1'b0, dvsr};
        next_rem = borrow ? {rem_q[WIDTH-2:0], quo_sr[WIDTH-1]} : diff[WIDTH-1:0];
        next_quo = {quo_sr[WIDTH-2:0], ~borrow};
        q_final  = neg_q ? (~next_quo + 1'b1) : next_quo;
        r_final  = neg_r ? (~next_rem + 1'b1) : next_rem;
    end

    // Control FSM, iteration registers and held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem_q       <= '0;
            quo_sr      <= '0;
            dvsr        <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quotient    <= {WIDTH{DIV_ZERO_QBIT}};
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            rem_q  <= '0;
                            quo_sr <= dvd_mag;
                            dvsr   <= dvs_mag;
                            count  <= CW'(WIDTH - 1);
                            neg_q  <= sop && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r  <= sop && dividend[WIDTH-1];
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= next_rem;
                    quo_sr <= next_quo;
                    count  <= count - 1'b1;
                    if (count == '0) begin
                        // Last bit: publish the sign-corrected result.
                        quotient    <= q_final;
                        remainder   <= r_final;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH = 32).
module tb_seq_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         signed_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    logic [2*W:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic rules: returns {dbz, rem, quo}.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
        logic [W-1:0] q;
        logic [W-1:0] r;
        int sa;
        int sb;
        if (b == 0) return {1'b1, a, {W{1'b1}}};
        if (!s) begin
            q = a / b;
            r = a - q * b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 0;
        end else begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end
        return {1'b0, r, q};
    endfunction

    // ---------------- driver ----------------
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int hold);
        logic [2*W:0] e;
        int  cyc;
        int  lat;
        bit  ir_bad;
        bit  hold_bad;
        exp_q.push_back(model(a, b, s));
        lat = (b == 0) ? 1 : W + 1;
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before_op", {31'd0, in_ready}, 32'd1);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        signed_op = $urandom_range(0, 1);
        cyc = 1;
        ir_bad = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (in_ready) ir_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (in_ready) ir_bad = 1'b1;
        e = exp_q.pop_front();
        check("latency", cyc, lat);
        check("in_ready_low_busy", {31'd0, ir_bad}, 32'd0);
        check("quotient", quotient, e[W-1:0]);
        check("remainder", remainder, e[2*W-1:W]);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[2*W]});
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = $urandom_range(0, 1);
            dividend = $urandom;
            divisor  = $urandom_range(1, 100);
            @(negedge clk);
            if (!out_valid || in_ready || quotient !== e[W-1:0] ||
                remainder !== e[2*W-1:W] || div_by_zero !== e[2*W]) hold_bad = 1'b1;
        end
        in_valid = 1'b0;
        if (hold > 0) check("held_stable", {31'd0, hold_bad}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", {31'd0, out_valid}, 32'd0);
        check("ready_return", {31'd0, in_ready}, 32'd1);
        check("result_kept", quotient, e[W-1:0]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           spur;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        signed_op = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed cases.
        do_op(32'd100, 32'd7, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        do_op(32'd5, 32'd9, 1'b0, 0);
        do_op(32'd1234, 32'd0, 1'b0, 0);
        do_op(32'd200, 32'd7, 1'b0, 10);
        do_op(32'd77, 32'd0, 1'b0, 3);

        // Reset in the middle of a calculation discards the operation.
        dividend = 32'd100;
        divisor  = 32'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        spur = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spur = 1'b1;
        end
        check("midrst_no_output", {31'd0, spur}, 32'd0);
        do_op(32'd50, 32'd5, 1'b0, 0);

        // Randomized unsigned operations.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            do_op(ra, rb, 1'b0, $urandom_range(0, 3));
        end

`ifdef SEQ_DIVIDER_SIGNED_EN
        do_op(-32'sd7, 32'd2, 1'b1, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        do_op(-32'sd20, 32'd0, 1'b1, 0);
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 30)) - 15);
            do_op(ra, rb, 1'b1, $urandom_range(0, 2));
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
